// File: rtl/ecc_alu_sequencer.sv
// Instruction sequencer for the ECC ALU core: owns a register file, issues one core op per
// instruction and writes the result back. Optional watchdog via `ECC_SEQ_TIMEOUT_EN.
module ecc_alu_sequencer #(
    parameter int unsigned W              = 256,
    parameter int unsigned NREG           = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned AW            = $clog2(NREG),
    localparam int unsigned IW            = 3 + 3 * AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [W-1:0]  i_prime,
    input  logic          i_instr_valid,
    output logic          o_instr_ready,
    input  logic [IW-1:0] i_instr,
    output logic          o_instr_done,
    output logic          o_illegal,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [W-1:0]  o_rd_data,
    output logic          o_busy,
    output logic          o_core_start,
    output logic [2:0]    o_core_sel,
    output logic [W-1:0]  o_core_a,
    output logic [W-1:0]  o_core_b,
    output logic [W-1:0]  o_core_prime,
    input  logic [W-1:0]  i_core_result,
    input  logic          i_core_done,
    input  logic          i_err_clr,
    output logic          o_err
);

    localparam logic [2:0] OpNop = 3'b000;
    localparam logic [2:0] OpInv = 3'b100;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e        r_state, w_state_d;
    logic [W-1:0]  r_regs [NREG];
    logic [2:0]    r_op;
    logic [AW-1:0] r_dst;
    logic [W-1:0]  r_opa, r_opb;
    logic          r_done, r_illegal;
    logic          w_accept, w_wb, w_retire, w_illegal, w_timeout, w_tmo_hit;

    logic [2:0]    w_op;
    logic [AW-1:0] w_dst, w_srca, w_srcb;

    assign w_op     = i_instr[IW-1 -: 3];
    assign w_dst    = i_instr[3*AW-1 -: AW];
    assign w_srca   = i_instr[2*AW-1 -: AW];
    assign w_srcb   = i_instr[AW-1:0];
    assign w_accept = i_instr_valid && (r_state == StIdle);

    always_comb begin
        w_state_d = r_state;
        w_wb      = 1'b0;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        w_timeout = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_op == OpNop) begin
                        w_retire = 1'b1;
                    end else if (w_op > OpInv) begin
                        w_illegal = 1'b1;
                    end else begin
                        w_state_d = StIssue;
                    end
                end
            end
            StIssue: w_state_d = StWait;
            StWait: begin
                if (i_core_done) begin
                    w_wb      = 1'b1;
                    w_retire  = 1'b1;
                    w_state_d = StIdle;
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                    w_retire  = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_op      <= '0;
            r_dst     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_done    <= w_retire;
            r_illegal <= w_illegal;
            // Operands are captured here, so dst may alias a source.
            if (w_accept) begin
                r_op  <= w_op;
                r_dst <= w_dst;
                r_opa <= r_regs[w_srca];
                r_opb <= r_regs[w_srcb];
            end
        end
    end

    // Host writes only land in IDLE, so they never race the writeback.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
        end else if (w_wb) begin
            r_regs[r_dst] <= i_core_result;
        end else if (i_wr_en && (r_state == StIdle)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef ECC_SEQ_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    assign w_tmo_hit = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_state_d == StIssue) begin
                r_cnt <= '0;
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A timeout in the same cycle as a clear keeps the error set.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_err = r_err;
`else
    logic w_unused;

    assign w_tmo_hit = 1'b0;
    assign w_unused  = i_err_clr ^ w_timeout;
    assign o_err     = 1'b0;
`endif

    assign o_instr_ready = (r_state == StIdle);
    assign o_busy        = (r_state != StIdle);
    assign o_instr_done  = r_done;
    assign o_illegal     = r_illegal;
    assign o_rd_data     = r_regs[i_rd_addr];
    assign o_core_start  = (r_state == StIssue);
    assign o_core_sel    = o_busy ? r_op  : 3'b000;
    assign o_core_a      = o_busy ? r_opa : '0;
    assign o_core_b      = o_busy ? r_opb : '0;
    assign o_core_prime  = i_prime;

endmodule
